// File: rtl/lift_request_arbiter_if.sv
// lift_request_arbiter_if: call inputs and request stream of lift_request_arbiter.
// LIFT_REQ_STATS_EN adds the drop_count status output.
interface lift_request_arbiter_if #(
    parameter int NUM_FLOORS = 64,
    parameter int FLOOR_W    = 7,
    parameter int DEPTH      = 8
);
    localparam int CW = $clog2(DEPTH) + 1;
    logic                  cabin_valid;
    logic [FLOOR_W-1:0]    cabin_floor;
    logic                  hall_valid;
    logic [FLOOR_W-1:0]    hall_floor;
    logic                  req_ready;
    logic                  req_valid;
    logic [FLOOR_W-1:0]    req_floor;
    logic [NUM_FLOORS-1:0] pending;
    logic [CW-1:0]         fifo_count;
    logic                  full;
    logic                  overflow;
    logic                  invalid;
`ifdef LIFT_REQ_STATS_EN
    logic [7:0]            drop_count;
`endif
    modport master (
        input  cabin_valid, cabin_floor, hall_valid, hall_floor, req_ready,
        output req_valid, req_floor, pending, fifo_count, full, overflow, invalid
`ifdef LIFT_REQ_STATS_EN
        , drop_count
`endif
    );
    modport slave (
        output cabin_valid, cabin_floor, hall_valid, hall_floor, req_ready,
        input  req_valid, req_floor, pending, fifo_count, full, overflow, invalid
`ifdef LIFT_REQ_STATS_EN
        , drop_count
`endif
    );
endinterface

// File: rtl/lift_request_arbiter.sv
// lift_request_arbiter: dedups cabin/hall calls and queues them in arrival order for the controller.
// LIFT_REQ_STATS_EN adds a saturating drop_count of overflow/invalid calls.
module lift_request_arbiter #(
    parameter int NUM_FLOORS = 64,
    parameter int FLOOR_W    = 7,
    parameter int DEPTH      = 8
) (
    input logic                   clk,
    input logic                   reset,
    lift_request_arbiter_if.master bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [FLOOR_W:0]    NF  = (FLOOR_W + 1)'(NUM_FLOORS);
    localparam logic [NUM_FLOORS-1:0] ONE = NUM_FLOORS'(1);
    logic [FLOOR_W-1:0]    mem_q [DEPTH];
    logic [FLOOR_W-1:0]    mem_d [DEPTH];
    logic [AW-1:0]         rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic [NUM_FLOORS-1:0] pending_q, pending_d, pend_pop, head_mask, cabin_mask, hall_mask;
    logic [FLOOR_W-1:0]    req_floor_q, req_floor_d;
    logic                  overflow_q, overflow_d, invalid_q, invalid_d;
    logic                  pop, hall_eff, cabin_ok, hall_ok, cabin_new, hall_new, cabin_do, hall_do;
    logic [CW:0]           space;
    always_comb begin
        pop        = count_q != '0 && bus.req_ready;
        head_mask  = ONE << mem_q[rd_ptr_q];
        cabin_mask = ONE << bus.cabin_floor;
        hall_mask  = ONE << bus.hall_floor;
        pend_pop   = pop ? pending_q & ~head_mask : pending_q;
        // A hall call to the cabin's floor in the same cycle is the same request.
        hall_eff   = bus.hall_valid && !(bus.cabin_valid && bus.hall_floor == bus.cabin_floor);
        cabin_ok   = {1'b0, bus.cabin_floor} < NF;
        hall_ok    = {1'b0, bus.hall_floor} < NF;
        cabin_new  = bus.cabin_valid && cabin_ok && (pend_pop & cabin_mask) == '0;
        hall_new   = hall_eff && hall_ok && (pend_pop & hall_mask) == '0;
        space      = (CW + 1)'(DEPTH) - {1'b0, count_q} + (CW + 1)'(pop);
        cabin_do   = cabin_new && space != '0;
        hall_do    = hall_new && space > {{CW{1'b0}}, cabin_do};
        overflow_d = (cabin_new && !cabin_do) || (hall_new && !hall_do);
        invalid_d  = (bus.cabin_valid && !cabin_ok) || (hall_eff && !hall_ok);
        mem_d      = mem_q;
        if (cabin_do) mem_d[wr_ptr_q] = bus.cabin_floor;
        if (hall_do) mem_d[wr_ptr_q + AW'(cabin_do)] = bus.hall_floor;
        pending_d  = pend_pop | (cabin_do ? cabin_mask : '0) | (hall_do ? hall_mask : '0);
        wr_ptr_d   = wr_ptr_q + AW'(cabin_do) + AW'(hall_do);
        rd_ptr_d   = rd_ptr_q + AW'(pop);
        count_d    = count_q + CW'(cabin_do) + CW'(hall_do) - CW'(pop);
        req_floor_d = count_d != '0 ? mem_d[rd_ptr_d] : req_floor_q;
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem_q       <= '{default: '0};
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            count_q     <= '0;
            pending_q   <= '0;
            req_floor_q <= '0;
            overflow_q  <= 1'b0;
            invalid_q   <= 1'b0;
        end else begin
            mem_q       <= mem_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            count_q     <= count_d;
            pending_q   <= pending_d;
            req_floor_q <= req_floor_d;
            overflow_q  <= overflow_d;
            invalid_q   <= invalid_d;
        end
    end
    assign bus.req_valid  = count_q != '0;
    assign bus.req_floor  = req_floor_q;
    assign bus.pending    = pending_q;
    assign bus.fifo_count = count_q;
    assign bus.full       = count_q == CW'(DEPTH);
    assign bus.overflow   = overflow_q;
    assign bus.invalid    = invalid_q;
`ifdef LIFT_REQ_STATS_EN
    logic [7:0] drop_count_q, drop_count_d;
    logic [8:0] drop_sum;
    always_comb begin
        drop_sum = {1'b0, drop_count_q} + 9'(cabin_new && !cabin_do) + 9'(hall_new && !hall_do)
                 + 9'(bus.cabin_valid && !cabin_ok) + 9'(hall_eff && !hall_ok);
        drop_count_d = drop_sum > 9'd255 ? 8'd255 : drop_sum[7:0];
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) drop_count_q <= '0;
        else drop_count_q <= drop_count_d;
    end
    assign bus.drop_count = drop_count_q;
`endif
endmodule

// File: tb/tb_lift_request_arbiter.sv
// tb_lift_request_arbiter: directed + random calls checked against a queue-based reference model.
module tb_lift_request_arbiter;
    localparam int NF = 64;
    localparam int FW = 7;
    localparam int D  = 8;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;
    lift_request_arbiter_if #(.NUM_FLOORS(NF), .FLOOR_W(FW), .DEPTH(D)) bus ();
    lift_request_arbiter #(.NUM_FLOORS(NF), .FLOOR_W(FW), .DEPTH(D)) dut (
        .clk(clk), .reset(reset), .bus(bus.master)
    );
    int checks = 0;
    int failures = 0;
    int q[$];
    int last_floor = 0;
    bit e_ovf = 0;
    bit e_inv = 0;
    int e_drop = 0;

    task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit in_queue(int f);
        foreach (q[i]) if (q[i] == f) return 1'b1;
        return 1'b0;
    endfunction

    task automatic offer(int f, inout int n);
        if (f >= NF) begin
            e_inv = 1'b1;
            n++;
        end else if (!in_queue(f)) begin
            if (q.size() < D) q.push_back(f);
            else begin
                e_ovf = 1'b1;
                n++;
            end
        end
    endtask

    task automatic model(bit cv, int cf, bit hv, int hf, bit rr);
        int n = 0;
        e_ovf = 1'b0;
        e_inv = 1'b0;
        if (rr && q.size() != 0) void'(q.pop_front());
        if (cv) offer(cf, n);
        if (hv && !(cv && hf == cf)) offer(hf, n);
        e_drop = (e_drop + n > 255) ? 255 : e_drop + n;
        if (q.size() != 0) last_floor = q[0];
    endtask

    task automatic model_reset();
        q.delete();
        last_floor = 0;
        e_ovf = 1'b0;
        e_inv = 1'b0;
        e_drop = 0;
    endtask

    task automatic check_all();
        logic [63:0] p = '0;
        foreach (q[i]) p[q[i]] = 1'b1;
        check("req_valid", 64'(bus.req_valid), 64'(q.size() != 0));
        check("req_floor", 64'(bus.req_floor), 64'(last_floor));
        check("pending", 64'(bus.pending), p);
        check("fifo_count", 64'(bus.fifo_count), 64'(q.size()));
        check("full", 64'(bus.full), 64'(q.size() == D));
        check("overflow", 64'(bus.overflow), 64'(e_ovf));
        check("invalid", 64'(bus.invalid), 64'(e_inv));
`ifdef LIFT_REQ_STATS_EN
        check("drop_count", 64'(bus.drop_count), 64'(e_drop));
`endif
    endtask

    task automatic cyc(bit cv, int cf, bit hv, int hf, bit rr);
        bus.cabin_valid = cv;
        bus.cabin_floor = FW'(cf);
        bus.hall_valid  = hv;
        bus.hall_floor  = FW'(hf);
        bus.req_ready   = rr;
        @(posedge clk);
        model(cv, cf, hv, hf, rr);
        #1;
        check_all();
    endtask

    initial begin
        int thr;
        reset = 1'b0;
        bus.cabin_valid = 1'b0;
        bus.cabin_floor = '0;
        bus.hall_valid  = 1'b0;
        bus.hall_floor  = '0;
        bus.req_ready   = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_all();
        @(negedge clk);
        reset = 1'b1;
        // single cabin call, held while not popped
        cyc(1, 27, 0, 0, 0);
        check("tp1_floor", 64'(bus.req_floor), 64'd27);
        repeat (10) cyc(0, 0, 0, 0, 0);
        check("tp1_hold", 64'(bus.req_floor), 64'd27);
        cyc(0, 0, 0, 0, 1);
        // duplicate suppression and order
        cyc(1, 3, 0, 0, 0);
        cyc(1, 15, 0, 0, 0);
        cyc(1, 3, 0, 0, 0);
        check("tp2_count", 64'(bus.fifo_count), 64'd2);
        cyc(0, 0, 0, 0, 1);
        check("tp2_second", 64'(bus.req_floor), 64'd15);
        cyc(0, 0, 0, 0, 1);
        check("tp2_empty", 64'(bus.req_valid), 64'd0);
        // simultaneous calls
        cyc(1, 10, 1, 6, 0);
        check("tp3_head", 64'(bus.req_floor), 64'd10);
        cyc(1, 20, 1, 20, 0);
        check("tp3_count", 64'(bus.fifo_count), 64'd3);
        repeat (3) cyc(0, 0, 0, 0, 1);
        // fill, then overflow with and without a pop
        for (int i = 0; i < D; i++) cyc(1, i, 0, 0, 0);
        cyc(1, 9, 1, 11, 0);
        check("tp4_ovf", 64'(bus.overflow), 64'd1);
        check("tp4_full", 64'(bus.full), 64'd1);
        cyc(1, 9, 1, 11, 1);
        check("tp4_ovf2", 64'(bus.overflow), 64'd1);
        check("tp4_head", 64'(bus.req_floor), 64'd1);
        repeat (D) cyc(0, 0, 0, 0, 1);
        // out-of-range floor
        cyc(0, 0, 1, 70, 0);
        check("tp5_inv", 64'(bus.invalid), 64'd1);
        cyc(0, 0, 0, 0, 0);
        // async reset during a pop
        cyc(1, 16, 0, 0, 0);
        cyc(1, 17, 0, 0, 0);
        cyc(1, 20, 0, 0, 0);
        cyc(0, 0, 0, 0, 1);
        #2 reset = 1'b0;
        #1;
        model_reset();
        check("rst_valid", 64'(bus.req_valid), 64'd0);
        check("rst_pending", 64'(bus.pending), 64'd0);
        check("rst_count", 64'(bus.fifo_count), 64'd0);
        @(negedge clk);
        reset = 1'b1;
        cyc(1, 17, 0, 0, 0);
        check("tp6_floor", 64'(bus.req_floor), 64'd17);
        cyc(0, 0, 0, 0, 1);
        // pop and re-push of the same floor
        cyc(1, 5, 0, 0, 0);
        cyc(1, 5, 1, 8, 1);
        check("repush_count", 64'(bus.fifo_count), 64'd2);
        repeat (2) cyc(0, 0, 0, 0, 1);
        // invalid spam drives drop counter to saturation
        repeat (140) cyc(1, 100, 1, 101, 0);
        // randomized traffic with varying drain rate
        for (int k = 0; k < 3000; k++) begin
            int cf, hf;
            if (k % 200 == 0) thr = $urandom_range(0, 2) * 35 + 15;
            cf = ($urandom_range(0, 15) == 0) ? int'($urandom_range(64, 127)) : int'($urandom_range(0, 23));
            hf = ($urandom_range(0, 15) == 0) ? int'($urandom_range(64, 127)) : int'($urandom_range(0, 23));
            cyc(1'($urandom_range(0, 1)), cf, 1'($urandom_range(0, 1)), hf, int'($urandom_range(0, 99)) < thr);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
